// File: rtl/l1_meta_pkg.sv
// ============================================================================
// Module      : l1_meta_pkg
// Description : Shared constants, the INIT/RUN state type and the parity
//               helper for the L1 data-cache tag/metadata array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package l1_meta_pkg;

    localparam int NSETS = 64;
    localparam int NWAYS = 4;
    localparam int TAG_W = 22;
    localparam int IDX_W = $clog2(NSETS);

    // INIT sweeps the array to zero after reset; RUN serves requests
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } meta_state_t;

    // Even parity over an entry. Callers zero-extend the entry to 64 bits,
    // which leaves the parity unchanged, so any TAG_W up to 64 can use it.
    function automatic logic meta_parity(input logic [63:0] entry);
        return ^entry;
    endfunction

endpackage

`default_nettype wire

// File: rtl/l1_meta_way.sv
// ============================================================================
// Module      : l1_meta_way
// Description : Storage for one way of the metadata array. There is one write
//               port with an enable, plus an asynchronous read at an
//               independent index. The entries have no reset; the owner
//               clears them with its init sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_meta_way
    import l1_meta_pkg::*;
#(
    parameter int SETS   = 64,
    parameter int DATA_W = 22
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(SETS)-1:0]  wr_idx,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(SETS)-1:0]  rd_idx,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [SETS];

    // Write updates the selected set at the clock edge
    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // The read is combinational. The top level registers the result, which
    // gives the one-cycle response latency.
    assign rd_data = mem[rd_idx];

endmodule

`default_nettype wire

// File: rtl/l1_meta_array.sv
// ============================================================================
// Module      : l1_meta_array
// Description : L1 D-cache tag/metadata array. Sweeps every set to zero after
//               reset, then serves one arbitrated request per cycle. A write
//               updates the masked ways. A read returns all ways of the set
//               on the following cycle.
//               Optional feature macro: META_PARITY_EN (per-entry even parity
//               with error injection on write and error report on read).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l1_meta_array #(
    parameter int NSETS  = l1_meta_pkg::NSETS,
    parameter int NWAYS  = l1_meta_pkg::NWAYS,
    parameter int TAG_W  = l1_meta_pkg::TAG_W,
    parameter int ADDR_W = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    output logic                       io_req_ready,
    input  logic                       io_req_valid,
    input  logic                       io_req_bits_write,
    input  logic [ADDR_W-1:0]          io_req_bits_addr,
    input  logic [$clog2(NSETS)-1:0]   io_req_bits_idx,
    input  logic [NWAYS-1:0]           io_req_bits_way_en,
    input  logic [TAG_W-1:0]           io_req_bits_data,
    output logic                       io_resp_valid,
    output logic [ADDR_W-1:0]          io_resp_bits_addr,
    output logic [NWAYS*TAG_W-1:0]     io_resp_bits_tag,
    output logic                       io_init_done
`ifdef META_PARITY_EN
    ,
    output logic [NWAYS-1:0]           io_resp_bits_perr,
    input  logic                       io_req_bits_perr_inj
`endif
);

    import l1_meta_pkg::*;

    localparam int IDX_W = $clog2(NSETS);
`ifdef META_PARITY_EN
    // The parity bit sits just above the tag
    localparam int ENT_W = TAG_W + 1;
`else
    localparam int ENT_W = TAG_W;
`endif
    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NSETS - 1);

    meta_state_t          state;
    meta_state_t          state_next;
    logic [IDX_W-1:0]     sweep_cnt;
    logic [IDX_W-1:0]     sweep_cnt_next;

    logic                 accept;
    logic                 rd_accept;
    logic                 wr_accept;

    logic [NWAYS-1:0]     way_we;
    logic [IDX_W-1:0]     wr_idx;
    logic [ENT_W-1:0]     wr_entry;
    logic [ENT_W-1:0]     rd_entry [NWAYS];
    logic [NWAYS*TAG_W-1:0] rd_tag_flat;
`ifdef META_PARITY_EN
    logic [NWAYS-1:0]     rd_perr;
`endif

    // Ready follows init-done directly; there is no other stall
    assign io_init_done = (state == ST_RUN);
    assign io_req_ready = io_init_done;
    assign accept       = io_req_valid & io_req_ready;
    assign rd_accept    = accept & ~io_req_bits_write;
    assign wr_accept    = accept &  io_req_bits_write;

    // Sweep FSM state and counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_INIT;
            sweep_cnt <= '0;
        end else begin
            state     <= state_next;
            sweep_cnt <= sweep_cnt_next;
        end
    end

    // Sweep FSM next state. The counter advances once per INIT cycle. The
    // edge that clears the last set also moves the FSM to RUN.
    always_comb begin
        state_next     = state;
        sweep_cnt_next = sweep_cnt;
        case (state)
            ST_INIT: begin
                sweep_cnt_next = sweep_cnt + IDX_W'(1);
                if (sweep_cnt == LAST_SET) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // Write-port mux. During the sweep, all ways get zero (tag and parity) at
    // the counter's set. In RUN, accepted writes go to the masked ways.
    always_comb begin
        way_we   = '0;
        wr_idx   = io_req_bits_idx;
        wr_entry = '0;
        if (state == ST_INIT) begin
            way_we = '1;
            wr_idx = sweep_cnt;
        end else if (wr_accept) begin
            way_we = io_req_bits_way_en;
`ifdef META_PARITY_EN
            wr_entry = {meta_parity(64'(io_req_bits_data)) ^ io_req_bits_perr_inj,
                        io_req_bits_data};
`else
            wr_entry = io_req_bits_data;
`endif
        end
    end

    for (genvar w = 0; w < NWAYS; w++) begin : g_way
        l1_meta_way #(
            .SETS   (NSETS),
            .DATA_W (ENT_W)
        ) u_way (
            .clock   (clock),
            .we      (way_we[w]),
            .wr_idx  (wr_idx),
            .wr_data (wr_entry),
            .rd_idx  (io_req_bits_idx),
            .rd_data (rd_entry[w])
        );

        assign rd_tag_flat[w*TAG_W +: TAG_W] = rd_entry[w][TAG_W-1:0];
`ifdef META_PARITY_EN
        assign rd_perr[w] = meta_parity(64'(rd_entry[w][TAG_W-1:0])) ^ rd_entry[w][TAG_W];
`endif
    end

    // Response registers: pulse valid for one cycle after each accepted
    // read and hold the payload until the next read
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            io_resp_valid     <= 1'b0;
            io_resp_bits_addr <= '0;
            io_resp_bits_tag  <= '0;
`ifdef META_PARITY_EN
            io_resp_bits_perr <= '0;
`endif
        end else begin
            io_resp_valid <= rd_accept;
            if (rd_accept) begin
                io_resp_bits_addr <= io_req_bits_addr;
                io_resp_bits_tag  <= rd_tag_flat;
`ifdef META_PARITY_EN
                io_resp_bits_perr <= rd_perr;
`endif
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_l1_meta_array.sv
// ============================================================================
// Module      : tb_l1_meta_array
// Description : Directed self-checking bench for l1_meta_array: init sweep
//               timing, masked writes, reads, back-to-back responses and
//               reset during the sweep. Also covers parity when
//               META_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l1_meta_array;

    localparam int AW = 32;
    localparam int TW = 22;
    localparam int NW = 4;
    localparam int IW = 6;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              io_req_ready;
    logic              io_req_valid;
    logic              io_req_bits_write;
    logic [AW-1:0]     io_req_bits_addr;
    logic [IW-1:0]     io_req_bits_idx;
    logic [NW-1:0]     io_req_bits_way_en;
    logic [TW-1:0]     io_req_bits_data;
    logic              io_resp_valid;
    logic [AW-1:0]     io_resp_bits_addr;
    logic [NW*TW-1:0]  io_resp_bits_tag;
    logic              io_init_done;
`ifdef META_PARITY_EN
    logic [NW-1:0]     io_resp_bits_perr;
    logic              io_req_bits_perr_inj;
`endif

    int checks   = 0;
    int failures = 0;

    l1_meta_array dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .io_req_ready       (io_req_ready),
        .io_req_valid       (io_req_valid),
        .io_req_bits_write  (io_req_bits_write),
        .io_req_bits_addr   (io_req_bits_addr),
        .io_req_bits_idx    (io_req_bits_idx),
        .io_req_bits_way_en (io_req_bits_way_en),
        .io_req_bits_data   (io_req_bits_data),
        .io_resp_valid      (io_resp_valid),
        .io_resp_bits_addr  (io_resp_bits_addr),
        .io_resp_bits_tag   (io_resp_bits_tag),
        .io_init_done       (io_init_done)
`ifdef META_PARITY_EN
        ,
        .io_resp_bits_perr    (io_resp_bits_perr),
        .io_req_bits_perr_inj (io_req_bits_perr_inj)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        io_req_valid       = 1'b0;
        io_req_bits_write  = 1'b0;
        io_req_bits_way_en = '0;
        io_req_bits_data   = '0;
`ifdef META_PARITY_EN
        io_req_bits_perr_inj = 1'b0;
`endif
    endtask

    task automatic drive_wr(input logic [IW-1:0] idx, input logic [NW-1:0] way_en,
                            input logic [TW-1:0] data);
        io_req_valid       = 1'b1;
        io_req_bits_write  = 1'b1;
        io_req_bits_idx    = idx;
        io_req_bits_way_en = way_en;
        io_req_bits_data   = data;
        step();
        idle();
    endtask

    task automatic drive_rd(input logic [IW-1:0] idx, input logic [AW-1:0] addr);
        io_req_valid      = 1'b1;
        io_req_bits_write = 1'b0;
        io_req_bits_idx   = idx;
        io_req_bits_addr  = addr;
        step();
        idle();
    endtask

    // Count edges from reset release to init_done (bounded), and note any
    // ready or response seen while the sweep is still running
    task automatic wait_init(output int edges, output int early_ready, output int pulses);
        edges = 0;
        early_ready = 0;
        pulses = 0;
        while (!io_init_done && edges < 200) begin
            if (io_req_ready)  early_ready++;
            if (io_resp_valid) pulses++;
            step();
            edges++;
        end
    endtask

    function automatic logic [NW*TW-1:0] ways(input logic [TW-1:0] w3, input logic [TW-1:0] w2,
                                             input logic [TW-1:0] w1, input logic [TW-1:0] w0);
        return {w3, w2, w1, w0};
    endfunction

    int edges;
    int early;
    int pulses;

    initial begin
        idle();
        io_req_bits_idx  = '0;
        io_req_bits_addr = '0;
        reset_n = 1'b0;
        step();
        step();

        // Reset state
        check("rst_ready",     32'(io_req_ready), 32'd0);
        check("rst_init_done", 32'(io_init_done), 32'd0);
        check("rst_resp_valid", 32'(io_resp_valid), 32'd0);
        check("rst_resp_addr", 128'(io_resp_bits_addr), 128'd0);
        check("rst_resp_tag",  128'(io_resp_bits_tag), 128'd0);

        // Release; a read presented during the sweep must be ignored
        reset_n = 1'b1;
        io_req_valid      = 1'b1;
        io_req_bits_write = 1'b0;
        io_req_bits_idx   = 6'd63;
        io_req_bits_addr  = 32'hDEAD_0000;
        wait_init(edges, early, pulses);
        check("init_edges",        128'(edges), 128'd64);
        check("init_ready_early",  128'(early), 128'd0);
        check("init_resp_pulses",  128'(pulses), 128'd0);
        check("init_no_resp_edge", 128'(io_resp_valid), 128'd0);
        idle();

        // Last set was cleared by the sweep
        drive_rd(6'd63, 32'h0000_0FC0);
        check("rd63_valid", 128'(io_resp_valid), 128'd1);
        check("rd63_tag",   128'(io_resp_bits_tag), 128'd0);
        check("rd63_addr",  128'(io_resp_bits_addr), 128'h0FC0);

        // Masked write, then read-after-write on the next cycle
        drive_wr(6'd5, 4'b0101, 22'h2ABCDE);
        check("wr5_no_resp", 128'(io_resp_valid), 128'd0);
        drive_rd(6'd5, 32'h0000_0140);
        check("rd5_valid", 128'(io_resp_valid), 128'd1);
        check("rd5_tag",   128'(io_resp_bits_tag), 128'(ways(22'h0, 22'h2ABCDE, 22'h0, 22'h2ABCDE)));
        check("rd5_addr",  128'(io_resp_bits_addr), 128'h140);

        // way_en = 0 is a no-op
        drive_wr(6'd9, 4'b0000, 22'h3FFFFF);
        drive_rd(6'd9, 32'h0000_0240);
        check("rd9_valid", 128'(io_resp_valid), 128'd1);
        check("rd9_tag",   128'(io_resp_bits_tag), 128'd0);

        // Back-to-back reads after distinct writes
        drive_wr(6'd1, 4'b1111, 22'h111111);
        drive_wr(6'd2, 4'b0001, 22'h222222);
        drive_wr(6'd3, 4'b1000, 22'h333333);
        drive_rd(6'd1, 32'h0000_1040);
        check("b2b1_valid", 128'(io_resp_valid), 128'd1);
        check("b2b1_tag",   128'(io_resp_bits_tag),
              128'(ways(22'h111111, 22'h111111, 22'h111111, 22'h111111)));
        drive_rd(6'd2, 32'h0000_2080);
        check("b2b2_valid", 128'(io_resp_valid), 128'd1);
        check("b2b2_tag",   128'(io_resp_bits_tag), 128'(ways(22'h0, 22'h0, 22'h0, 22'h222222)));
        drive_rd(6'd3, 32'h0000_30C0);
        check("b2b3_valid", 128'(io_resp_valid), 128'd1);
        check("b2b3_tag",   128'(io_resp_bits_tag), 128'(ways(22'h333333, 22'h0, 22'h0, 22'h0)));
        check("b2b3_addr",  128'(io_resp_bits_addr), 128'h30C0);

        // No pulse after a write; payload holds the last read
        drive_wr(6'd4, 4'b0011, 22'h044444);
        check("post_wr_no_resp", 128'(io_resp_valid), 128'd0);
        check("hold_addr", 128'(io_resp_bits_addr), 128'h30C0);
        check("hold_tag",  128'(io_resp_bits_tag), 128'(ways(22'h333333, 22'h0, 22'h0, 22'h0)));

        // Reset while a response is pending drops it
        io_req_valid      = 1'b1;
        io_req_bits_write = 1'b0;
        io_req_bits_idx   = 6'd5;
        io_req_bits_addr  = 32'h0000_0144;
        step();
        idle();
        reset_n = 1'b0;
        #1;
        check("midrd_resp_valid", 128'(io_resp_valid), 128'd0);
        check("midrd_resp_addr",  128'(io_resp_bits_addr), 128'd0);
        check("midrd_init_done",  128'(io_init_done), 128'd0);
        step();

        // Reset at sweep cycle 30, then a full sweep from set 0
        reset_n = 1'b1;
        for (int i = 0; i < 30; i++) step();
        check("sweep30_ready", 128'(io_req_ready), 128'd0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        io_req_valid      = 1'b1;
        io_req_bits_write = 1'b0;
        io_req_bits_idx   = 6'd0;
        io_req_bits_addr  = 32'h0000_0000;
        wait_init(edges, early, pulses);
        check("reinit_edges",        128'(edges), 128'd64);
        check("reinit_ready_early",  128'(early), 128'd0);
        check("reinit_resp_pulses",  128'(pulses), 128'd0);
        check("reinit_no_resp_edge", 128'(io_resp_valid), 128'd0);
        idle();

        // The sweep cleared earlier contents
        drive_rd(6'd5, 32'h0000_0140);
        check("reinit_rd5_tag", 128'(io_resp_bits_tag), 128'd0);

`ifdef META_PARITY_EN
        io_req_bits_perr_inj = 1'b1;
        drive_wr(6'd7, 4'b0010, 22'h000001);
        drive_rd(6'd7, 32'h0000_01C0);
        check("perr_inj",     128'(io_resp_bits_perr), 128'b0010);
        check("perr_inj_tag", 128'(io_resp_bits_tag), 128'(ways(22'h0, 22'h0, 22'h1, 22'h0)));
        drive_wr(6'd7, 4'b0010, 22'h000001);
        drive_rd(6'd7, 32'h0000_01C0);
        check("perr_clean",   128'(io_resp_bits_perr), 128'b0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
